// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared memory port: fetch (0) vs data (1).
// Latches the winning request, holds the port for the transaction, returns ack/err/rdata.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic [DATA_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [3:0]        be0_i,
    input  logic [3:0]        be1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              sel_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Counter value seen on the edge that expires the wait window.
    localparam logic [CNT_W-1:0] LAST_WAIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_grant_q;
    logic               ack0_q, ack1_q, err_q, sel_q, busy_q, mem_req_q, mem_we_q;
    logic [DATA_W-1:0]  rdata_q, mem_addr_q, mem_wdata_q;
    logic [3:0]         mem_be_q;

    logic               any_req_d;
    logic               grant_d;

    always_comb begin
        any_req_d = req0_i | req1_i;
        if (req0_i && req1_i) begin
            grant_d = ~last_grant_q;
        end else begin
            grant_d = req1_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
            sel_q        <= 1'b0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        sel_q        <= grant_d;
                        last_grant_q <= grant_d;
                        mem_addr_q   <= grant_d ? addr1_i  : addr0_i;
                        mem_wdata_q  <= grant_d ? wdata1_i : wdata0_i;
                        mem_we_q     <= grant_d ? we1_i    : we0_i;
                        mem_be_q     <= grant_d ? be1_i    : be0_i;
                        mem_req_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    // A completion on the expiry edge takes precedence over the timeout.
                    if (mem_ready_i) begin
                        rdata_q   <= mem_rdata_i;
                        ack0_q    <= ~sel_q;
                        ack1_q    <= sel_q;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (TIMEOUT != 0 && cnt_q == LAST_WAIT) begin
                            rdata_q   <= '0;
                            ack0_q    <= ~sel_q;
                            ack1_q    <= sel_q;
                            err_q     <= 1'b1;
                            mem_req_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign sel_o       = sel_q;
    assign busy_o      = busy_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed multi-cycle sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1, mem_ready;
    logic [DW-1:0] addr0, addr1, wdata0, wdata1, mem_rdata;
    logic [3:0]    be0, be1;
    logic          ack0, ack1, err, sel, busy, mem_req, mem_we;
    logic [DW-1:0] rdata, mem_addr, mem_wdata;
    logic [3:0]    mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .CNT_W(8), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset),
        .req0_i(req0), .req1_i(req1),
        .addr0_i(addr0), .addr1_i(addr1),
        .wdata0_i(wdata0), .wdata1_i(wdata1),
        .we0_i(we0), .we1_i(we1),
        .be0_i(be0), .be1_i(be1),
        .ack0_o(ack0), .ack1_o(ack1), .err_o(err), .rdata_o(rdata),
        .sel_o(sel), .busy_o(busy), .mem_req_o(mem_req),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    typedef struct {
        logic          who;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          we;
        logic [3:0]    be;
        int            rdy_dly;   // BUSY edges with mem_ready low before it rises
        logic [DW-1:0] mdata;
        int            exp_lat;   // edges from grant edge to ack edge
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; be0 = 0; be1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic run_vec(input vec_t v);
        logic done;
        done = 0;
        @(negedge clk);
        req0 = (v.who == 1'b0);
        req1 = (v.who == 1'b1);
        if (v.who) begin
            addr1 = v.addr; wdata1 = v.wdata; we1 = v.we; be1 = v.be;
            addr0 = $urandom; wdata0 = $urandom; we0 = ~v.we; be0 = ~v.be;
        end else begin
            addr0 = v.addr; wdata0 = v.wdata; we0 = v.we; be0 = v.be;
            addr1 = $urandom; wdata1 = $urandom; we1 = ~v.we; be1 = ~v.be;
        end
        mem_ready = 0;
        @(posedge clk); #1;
        check("grant_ctrl", {ack0, ack1, err, mem_req, busy, sel}, {3'b000, 2'b11, v.who});
        check("grant_fields", {mem_addr, mem_wdata, mem_we, mem_be}, {v.addr, v.wdata, v.we, v.be});
        for (int k = 1; k <= 8 && !done; k++) begin
            @(negedge clk);
            mem_ready = (k == v.rdy_dly + 1);
            mem_rdata = v.mdata;
            if (v.who) addr1 = ~v.addr; else addr0 = ~v.addr;
            @(posedge clk); #1;
            if (k < v.exp_lat) begin
                check("busy_ctrl", {ack0, ack1, err, mem_req, busy, sel}, {3'b000, 2'b11, v.who});
                check("busy_hold", {mem_addr, mem_wdata, mem_we, mem_be}, {v.addr, v.wdata, v.we, v.be});
            end else begin
                check("ack_ctrl", {ack0, ack1, err, mem_req, busy, sel},
                      {~v.who, v.who, v.exp_err, 2'b00, v.who});
                check("ack_rdata", rdata, v.exp_rdata);
                done = 1;
            end
        end
        if (!done) check("ack_seen", 0, 1);
        @(negedge clk);
        req0 = 0; req1 = 0;
        mem_ready = 1;
        @(posedge clk); #1;
        check("idle_after_ack", {ack0, ack1, err, mem_req, busy}, 5'b0);
        check("idle_hold", {mem_addr, rdata}, {v.addr, v.exp_rdata});
        @(negedge clk);
        mem_ready = 0;
    endtask

    // Reference model state (transaction level)
    logic          m_busy, m_sel, m_last, m_we;
    int            m_wait;
    logic [DW-1:0] m_addr, m_wdata, m_rdata;
    logic [3:0]    m_be;
    logic          e_ack0, e_ack1, e_err;

    initial begin
        int n_ack;
        int bad_both;
        logic order[4];
        int cyc[4];

        reset = 1;
        clear_inputs();
        vecs[0] = '{1'b0, 32'h3000, 32'h0, 1'b0, 4'hF, 1, 32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 32'h4000, 32'h12345678, 1'b1, 4'b0011, 2, 32'hCAFE0001, 3, 1'b0, 32'hCAFE0001};
        vecs[2] = '{1'b0, 32'h5000, 32'h0, 1'b0, 4'hF, 255, 32'h11112222, 4, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 32'h5004, 32'h0, 1'b0, 4'h1, 3, 32'hA5A55A5A, 4, 1'b0, 32'hA5A55A5A};
        vecs[4] = '{1'b0, 32'h7008, 32'h0, 1'b0, 4'hC, 0, 32'h0BADF00D, 1, 1'b0, 32'h0BADF00D};
        vecs[5] = '{1'b1, 32'h800C, 32'hFFFF0000, 1'b1, 4'h8, 255, 32'h55555555, 4, 1'b1, 32'h0};

        do_reset();
        #1;
        check("reset_ctrl", {ack0, ack1, err, sel, busy, mem_req, mem_we, mem_be}, 11'b0);
        check("reset_data", {rdata, mem_addr, mem_wdata}, 96'b0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Both requesters held high: strict alternation starting with fetch.
        do_reset();
        req0 = 1; req1 = 1; mem_ready = 1;
        addr0 = 32'hA0; addr1 = 32'hB0;
        n_ack = 0; bad_both = 0;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            @(posedge clk); #1;
            if (ack0 && ack1) bad_both++;
            if (ack0 || ack1) begin
                order[n_ack] = ack1;
                cyc[n_ack] = c;
                n_ack++;
            end
        end
        check("t2_ack_count", n_ack, 4);
        check("t2_no_double_ack", bad_both, 0);
        if (n_ack == 4) begin
            check("t2_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
            for (int i = 1; i < 4; i++) check("t2_gap", cyc[i] - cyc[i-1], 2);
        end
        @(negedge clk);
        clear_inputs();

        // Reset in the 2nd BUSY cycle, then fetch must win the first tie.
        do_reset();
        req0 = 1; addr0 = 32'h6000;
        @(posedge clk); #1;
        check("t6_granted", {busy, mem_req, sel}, 3'b110);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        check("t6_reset_ctrl", {ack0, ack1, err, mem_req, busy}, 5'b0);
        @(negedge clk);
        reset = 0; req1 = 1; addr1 = 32'h6100;
        @(posedge clk); #1;
        check("t6_first_grant", {busy, sel, mem_addr}, {2'b10, 32'h6000});

        // Random traffic against the reference model.
        do_reset();
        m_busy = 0; m_sel = 0; m_last = 1; m_we = 0; m_wait = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            addr0 = $urandom; addr1 = $urandom;
            wdata0 = $urandom; wdata1 = $urandom;
            we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            be0 = 4'($urandom_range(0, 15)); be1 = 4'($urandom_range(0, 15));
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            e_ack0 = 0; e_ack1 = 0; e_err = 0;
            if (!m_busy) begin
                if (req0 || req1) begin
                    m_sel  = (req0 && req1) ? !m_last : req1;
                    m_last = m_sel;
                    m_addr  = m_sel ? addr1 : addr0;
                    m_wdata = m_sel ? wdata1 : wdata0;
                    m_we    = m_sel ? we1 : we0;
                    m_be    = m_sel ? be1 : be0;
                    m_busy = 1;
                    m_wait = 0;
                end
            end else if (mem_ready) begin
                e_ack0 = !m_sel; e_ack1 = m_sel;
                m_rdata = mem_rdata;
                m_busy = 0;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    e_ack0 = !m_sel; e_ack1 = m_sel; e_err = 1;
                    m_rdata = 0;
                    m_busy = 0;
                end
            end
            @(posedge clk); #1;
            check("rnd_ctrl", {ack0, ack1, err, sel, busy, mem_req, mem_we, mem_be},
                  {e_ack0, e_ack1, e_err, m_sel, m_busy, m_busy, m_we, m_be});
            check("rnd_rdata", rdata, m_rdata);
            check("rnd_fields", {mem_addr, mem_wdata}, {m_addr, m_wdata});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
